elevator_ctrl: RTL and testbench
================================

# elevator_ctrl

Scheduling controller for the elevator car. It latches hall/car floor calls and services them in SCAN order: keep the current direction while calls remain ahead, otherwise reverse. It sequences car movement and door dwell from the 1 Hz strobe produced by the clock divider. Everything runs in the clk_100MHz domain, with the strobe used as a clock enable; the floor and door outputs feed the display and LED logic.

## Interface
- NUM_FLOORS, 4: number of floors, legal range 2..8.
- FLOOR_W, 2: width of floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- TRAVEL_TICKS, 2: ticks to move one floor, at least 1.
- DOOR_TICKS, 3: ticks door stays open, at least 1.

Ports:
- clk_100MHz  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle strobe at 1 Hz from the clock divider.
- call_req  in  NUM_FLOORS  per-floor call; a level or a one-cycle pulse both register.
- current_floor  out  FLOOR_W  floor the car is at or last passed.
- moving_up  out  1  car travelling upward.
- moving_down  out  1  car travelling downward.
- door_open  out  1  door open at current_floor.
- pending  out  NUM_FLOORS  latched, unserviced calls.

## Operation
Register and state rules:
- pending <= (pending | call_req) every cycle, with two exceptions:
  - The bit for current_floor is forced to 0 in the cycle the FSM enters DOOR.
  - That bit is also held at 0 for the whole time the FSM is in DOOR.
- dir register: 1 = up, 0 = down. Updated only on entry to MOVE.
- "above" = any pending bit with index > current_floor; "below" = any with index < current_floor.
- tick_cnt: counts ticks within a state and clears on every state entry.

FSM states:
- IDLE: evaluated every clock, not gated by tick.
  - If pending[current_floor] is set, go to DOOR.
  - Else if calls exist in direction dir, go to MOVE and keep dir.
  - Else if calls exist in the opposite direction, go to MOVE and flip dir.
  - Else stay in IDLE.
- MOVE: moving_up = dir and moving_down = !dir.
  - On the tick that makes tick_cnt reach TRAVEL_TICKS, current_floor steps by ±1 in the same edge, and the FSM goes to ARRIVE.
- ARRIVE: lasts one cycle.
  - If pending[current_floor] is set, go to DOOR.
  - Else if calls exist in direction dir, go to MOVE.
  - Else go to IDLE.
- DOOR: door_open = 1.
  - On the tick that makes tick_cnt reach DOOR_TICKS, go to IDLE.

Boundary rules:
- current_floor never decrements below 0 or increments above NUM_FLOORS-1.
- MOVE is entered only when a call exists in that direction, which guarantees the limits above; an assertion in the bench checks them.
- A call for current_floor while in DOOR is dropped. It does not extend the dwell.
- A call for current_floor while in MOVE or ARRIVE is latched. It is serviced on a later visit unless ARRIVE is at that floor.
- Calls arriving in the same cycle as a tick are latched normally. Decisions use the registered pending value, so such a call affects the decision one cycle later.
- Reset asserted mid-operation, sampled on any edge, returns all state to reset values in the next cycle, including discarding pending calls.

## Timing
- Reset values:
  - Outputs: current_floor = 0, moving_up = 0, moving_down = 0, door_open = 0, pending = 0.
  - Internal: FSM = IDLE, dir = up, tick_cnt = 0.
- All outputs are registered. No combinational path runs from an input to an output.
- Call latency: call_req asserted at edge n appears in pending at edge n+1.
- Leaving IDLE: IDLE leaves at edge n+2 at the earliest.
- Travel time per floor: exactly TRAVEL_TICKS ticks from MOVE entry. The entry tick itself is not counted; counting starts with the first tick after entry.
- Passing through a floor without stopping adds 1 cycle (ARRIVE) plus re-entry into MOVE, so the next floor again takes TRAVEL_TICKS ticks.
- Door dwell: exactly DOOR_TICKS ticks after DOOR entry.
- moving_up and moving_down are never both 1. door_open is never 1 together with either of them.

## Test plan
- Reset with call_req held at 4'b1111.
  - pending = 0 and all outputs at reset values while reset is high.
  - After release, pending = 4'b1111 one cycle later; the door opens at floor 0 and bit 0 clears.
- Pulse call floor 3 from idle at floor 0, with TRAVEL_TICKS = 2 and DOOR_TICKS = 3.
  - moving_up for 6 ticks; current_floor steps 1, 2, 3.
  - door_open for 3 ticks, then IDLE with pending = 0.
- SCAN ordering: car at floor 2 moving up toward 3; calls at 1 and 3 are pending.
  - Car serves 3 first, then reverses and serves 1.
  - The floor sequence shows no stop at floor 2.
- Call for current_floor during DOOR.
  - Not latched; dwell still exactly DOOR_TICKS.
  - Same call issued 1 cycle after DOOR exit reopens the door.
- Call and tick in the same cycle while in IDLE with no other calls.
  - Call appears in pending the next cycle; MOVE is entered one cycle after that.
  - The simultaneous tick is not counted toward travel.
- Assert reset for 1 cycle mid-MOVE between floors 1 and 2.
  - current_floor = 0, pending = 0, FSM = IDLE, and all motion and door outputs = 0 on the next cycle.

Source files
------------

// File: rtl/elevator_ctrl.sv
// SCAN-order elevator scheduler: latches floor calls, moves the car one floor per
// TRAVEL_TICKS strobes and holds the door open for DOOR_TICKS strobes.
module elevator_ctrl #(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = 2,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MOVE   = 2'd1;
    localparam logic [1:0] S_ARRIVE = 2'd2;
    localparam logic [1:0] S_DOOR   = 2'd3;

    localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   TRAVEL_C = CNT_W'(TRAVEL_TICKS);
    localparam logic [CNT_W-1:0]   DOOR_C   = CNT_W'(DOOR_TICKS);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE = {{(FLOOR_W-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic                  dir_q, dir_d;
    logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  moving_up_q, moving_up_d;
    logic                  moving_down_q, moving_down_d;
    logic                  door_open_q, door_open_d;

    logic [NUM_FLOORS-1:0] above_mask, below_mask, here_mask;
    logic                  calls_above, calls_below, call_here;
    logic                  calls_ahead, calls_behind;
    logic [CNT_W-1:0]      tick_cnt_inc;

    // Per-floor position masks relative to the car, from the registered floor only.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor_mask
        localparam logic [FLOOR_W-1:0] FLOOR_IDX = FLOOR_W'(gi);
        assign above_mask[gi] = (FLOOR_IDX > floor_q);
        assign below_mask[gi] = (FLOOR_IDX < floor_q);
        assign here_mask[gi]  = (FLOOR_IDX == floor_q);
    end

    assign calls_above  = |(pending_q & above_mask);
    assign calls_below  = |(pending_q & below_mask);
    assign call_here    = |(pending_q & here_mask);
    assign calls_ahead  = dir_q ? calls_above : calls_below;
    assign calls_behind = dir_q ? calls_below : calls_above;
    assign tick_cnt_inc = tick_cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        tick_cnt_d = tick_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (call_here) begin
                    state_d = S_DOOR;
                end else if (calls_ahead) begin
                    state_d = S_MOVE;
                end else if (calls_behind) begin
                    state_d = S_MOVE;
                    dir_d   = ~dir_q;
                end
            end
            S_MOVE: begin
                if (tick) begin
                    if (tick_cnt_inc == TRAVEL_C) begin
                        floor_d = dir_q ? (floor_q + FLOOR_ONE) : (floor_q - FLOOR_ONE);
                        state_d = S_ARRIVE;
                    end else begin
                        tick_cnt_d = tick_cnt_inc;
                    end
                end
            end
            S_ARRIVE: begin
                if (call_here) begin
                    state_d = S_DOOR;
                end else if (calls_ahead) begin
                    state_d = S_MOVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (tick) begin
                    if (tick_cnt_inc == DOOR_C) begin
                        state_d = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_inc;
                    end
                end
            end
        endcase

        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end

        // A call for the car's own floor is swallowed while the door is (or is about to be) open.
        pending_d = pending_q | call_req;
        if ((state_d == S_DOOR) || (state_q == S_DOOR)) begin
            pending_d = pending_d & ~here_mask;
        end

        moving_up_d   = (state_d == S_MOVE) && dir_d;
        moving_down_d = (state_d == S_MOVE) && !dir_d;
        door_open_d   = (state_d == S_DOOR);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q       <= S_IDLE;
            dir_q         <= 1'b1;
            tick_cnt_q    <= '0;
            floor_q       <= '0;
            pending_q     <= '0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            tick_cnt_q    <= tick_cnt_d;
            floor_q       <= floor_d;
            pending_q     <= pending_d;
            moving_up_q   <= moving_up_d;
            moving_down_q <= moving_down_d;
            door_open_q   <= door_open_d;
        end
    end

    assign current_floor = floor_q;
    assign moving_up     = moving_up_q;
    assign moving_down   = moving_down_q;
    assign door_open     = door_open_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios with literal expectations plus a
// randomized run, all shadowed by a phase/countdown model compared every cycle.
module tb_elevator_ctrl;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int TT = 2;
    localparam int DT = 3;

    logic          clk_100MHz = 1'b0;
    logic          reset;
    logic          tick;
    logic [NF-1:0] call_req;
    logic [FW-1:0] current_floor;
    logic          moving_up;
    logic          moving_down;
    logic          door_open;
    logic [NF-1:0] pending;

    elevator_ctrl #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .TRAVEL_TICKS(TT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .tick         (tick),
        .call_req     (call_req),
        .current_floor(current_floor),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .door_open    (door_open),
        .pending      (pending)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int checks   = 0;
    int failures = 0;
    int printed  = 0;
    bit check_en = 0;

    // Reference model: phases with a countdown of remaining strobes.
    localparam int P_IDLE = 0, P_TRAVEL = 1, P_ARRIVE = 2, P_DWELL = 3;
    int          m_floor = 0;
    int          m_dir   = 1;
    int          m_phase = P_IDLE;
    int          m_left  = 0;
    logic [NF-1:0] m_pend = '0;

    always @(posedge clk_100MHz) begin
        int            ph_n;
        logic [NF-1:0] p_n;
        bit            up_calls, down_calls, here, ahead;
        if (reset) begin
            m_floor = 0; m_dir = 1; m_phase = P_IDLE; m_left = 0; m_pend = '0;
        end else begin
            up_calls = 0; down_calls = 0;
            for (int f = 0; f < NF; f++) begin
                if (m_pend[f] && f > m_floor) up_calls = 1;
                if (m_pend[f] && f < m_floor) down_calls = 1;
            end
            here  = m_pend[m_floor];
            ahead = (m_dir != 0) ? up_calls : down_calls;
            ph_n  = m_phase;
            p_n   = m_pend | call_req;
            case (m_phase)
                P_IDLE: begin
                    if (here) begin
                        ph_n = P_DWELL; m_left = DT;
                    end else if (ahead) begin
                        ph_n = P_TRAVEL; m_left = TT;
                    end else if (up_calls || down_calls) begin
                        m_dir = (m_dir != 0) ? 0 : 1;
                        ph_n = P_TRAVEL; m_left = TT;
                    end
                end
                P_TRAVEL: begin
                    if (tick) begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_floor = m_floor + ((m_dir != 0) ? 1 : -1);
                            ph_n = P_ARRIVE;
                        end
                    end
                end
                P_ARRIVE: begin
                    if (here) begin
                        ph_n = P_DWELL; m_left = DT;
                    end else if (ahead) begin
                        ph_n = P_TRAVEL; m_left = TT;
                    end else begin
                        ph_n = P_IDLE;
                    end
                end
                default: begin
                    if (tick) begin
                        m_left = m_left - 1;
                        if (m_left == 0) ph_n = P_IDLE;
                    end
                end
            endcase
            if (ph_n == P_DWELL || m_phase == P_DWELL) p_n[m_floor] = 1'b0;
            m_pend  = p_n;
            m_phase = ph_n;
        end
    end

    // Per-cycle comparison against the model plus the safety invariants.
    always @(negedge clk_100MHz) begin
        int  e_floor;
        bit  e_up, e_dn, e_door;
        if (check_en) begin
            e_floor = m_floor;
            e_up    = (m_phase == P_TRAVEL) && (m_dir != 0);
            e_dn    = (m_phase == P_TRAVEL) && (m_dir == 0);
            e_door  = (m_phase == P_DWELL);
            checks++;
            if (int'(current_floor) != e_floor || moving_up !== e_up || moving_down !== e_dn ||
                door_open !== e_door || pending !== m_pend) begin
                failures++;
                if (printed < 40) begin
                    printed++;
                    $display("FAIL model t=%0t dut floor=%0d up=%b dn=%b door=%b pend=%b required floor=%0d up=%b dn=%b door=%b pend=%b",
                             $time, current_floor, moving_up, moving_down, door_open, pending,
                             e_floor, e_up, e_dn, e_door, m_pend);
                end
            end
            checks++;
            assert (int'(current_floor) <= NF - 1 && !(moving_up && moving_down) &&
                    !(door_open && (moving_up || moving_down)))
            else begin
                failures++;
                if (printed < 40) begin
                    printed++;
                    $display("FAIL invariant t=%0t floor=%0d up=%b dn=%b door=%b required floor<=%0d and exclusive outputs",
                             $time, current_floor, moving_up, moving_down, door_open, NF - 1);
                end
            end
        end
    end

    // Directed-stimulus helpers.
    int n_up_ticks = 0, n_door_ticks = 0, tick_phase = 0, last_floor = 0;
    bit last_door = 0;
    int floor_log[$];
    int door_log[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        n_up_ticks = 0; n_door_ticks = 0;
        floor_log.delete(); door_log.delete();
        last_floor = int'(current_floor); last_door = door_open;
    endtask

    task automatic cyc(input logic [NF-1:0] c, input logic t);
        call_req = c;
        tick     = t;
        if (t && moving_up) n_up_ticks++;
        if (t && door_open) n_door_ticks++;
        @(posedge clk_100MHz);
        #1;
        if (int'(current_floor) != last_floor) floor_log.push_back(int'(current_floor));
        last_floor = int'(current_floor);
        if (door_open && !last_door) door_log.push_back(int'(current_floor));
        last_door = door_open;
    endtask

    function automatic logic paced_tick();
        tick_phase++;
        return (tick_phase % 4) == 0;
    endfunction

    function automatic int enc(input int q[$]);
        int e = 0;
        foreach (q[i]) e = e * 10 + q[i] + 1;
        return e;
    endfunction

    task automatic run_until_quiet(input int max_cycles);
        int quiet = 0;
        for (int i = 0; i < max_cycles && quiet < 2; i++) begin
            cyc('0, paced_tick());
            if (pending == '0 && !door_open && !moving_up && !moving_down) quiet++;
            else quiet = 0;
        end
        chk("quiet_timeout", quiet, 2);
    endtask

    task automatic run_until_up_at(input int fl, input int max_cycles);
        bit hit = 0;
        for (int i = 0; i < max_cycles && !hit; i++) begin
            cyc('0, paced_tick());
            hit = (int'(current_floor) == fl) && moving_up;
        end
        chk("reach_timeout", int'(hit), 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc('0, 1'b0);
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; call_req = '1;
        @(posedge clk_100MHz); #1;
        check_en = 1;
        repeat (2) begin @(posedge clk_100MHz); #1; end

        // Reset held with every call asserted.
        chk("rst_pending", int'(pending), 0);
        chk("rst_outputs", int'({current_floor, moving_up, moving_down, door_open}), 0);
        clear_logs();
        reset = 1'b0;
        cyc(4'b1111, 1'b0);
        chk("rel_pending", int'(pending), 4'b1111);
        chk("rel_door_closed", int'(door_open), 0);
        cyc('0, 1'b0);
        chk("rel_door0_open", int'(door_open), 1);
        chk("rel_bit0_clear", int'(pending), 4'b1110);
        run_until_quiet(400);
        chk("rel_door_floors", enc(door_log), 1234);
        chk("rel_final_floor", int'(current_floor), 3);

        // Single call from floor 0 to floor 3.
        pulse_reset();
        cyc(4'b1000, 1'b0);
        run_until_quiet(400);
        chk("trip_up_ticks", n_up_ticks, 6);
        chk("trip_floor_seq", enc(floor_log), 234);
        chk("trip_door_ticks", n_door_ticks, 3);
        chk("trip_door_floors", enc(door_log), 4);
        chk("trip_pending", int'(pending), 0);

        // SCAN: moving up past floor 2 toward 3 with a new call behind at 1.
        pulse_reset();
        cyc(4'b1000, 1'b0);
        run_until_up_at(2, 200);
        clear_logs();
        cyc(4'b0010, 1'b0);
        run_until_quiet(400);
        chk("scan_door_floors", enc(door_log), 42);
        chk("scan_floor_seq", enc(floor_log), 432);

        // Own-floor call during the dwell is dropped; one after exit reopens.
        clear_logs();
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b0);
        chk("dwell_open", int'(door_open), 1);
        for (int i = 0; i < 100 && door_open; i++) begin
            cyc(4'b0010, paced_tick());
            chk("dwell_call_dropped", int'(pending[1]), 0);
        end
        chk("dwell_ticks", n_door_ticks, DT);
        cyc(4'b0010, 1'b0);
        chk("reopen_latched", int'(pending), 4'b0010);
        cyc('0, 1'b0);
        chk("reopen_door", int'(door_open), 1);
        run_until_quiet(400);

        // Call coinciding with a tick while idle at floor 1.
        cyc(4'b1000, 1'b1);
        chk("cotick_pending", int'(pending), 4'b1000);
        chk("cotick_still_idle", int'(moving_up), 0);
        cyc('0, 1'b1);
        chk("cotick_move", int'(moving_up), 1);
        cyc('0, 1'b1);
        chk("cotick_first_tick_floor", int'(current_floor), 1);
        cyc('0, 1'b1);
        chk("cotick_second_tick_floor", int'(current_floor), 2);
        run_until_quiet(400);

        // Reset pulse mid-travel between floors 1 and 2.
        pulse_reset();
        cyc(4'b0100, 1'b0);
        run_until_up_at(1, 200);
        chk("midmove_pending", int'(pending), 4'b0100);
        reset = 1'b1;
        cyc('0, 1'b0);
        reset = 1'b0;
        chk("midrst_all", int'({current_floor, moving_up, moving_down, door_open, pending}), 0);
        repeat (4) cyc('0, 1'b1);
        chk("midrst_stays_idle", int'({current_floor, moving_up, door_open, pending}), 0);

        // Randomized traffic, covered by the per-cycle model comparison.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 799) == 0);
            cyc(($urandom_range(0, 7) == 0) ? NF'($urandom_range(1, (1 << NF) - 1)) : '0,
                $urandom_range(0, 2) == 0);
        end
        reset = 1'b0;
        cyc('0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
